step_counter: RTL and testbench

Parametrised up/down step counter: the general-purpose successor to the fixed 8-bit free-running counter, used for timers, event counting and test-bench stimulus sequencing. Adds a programmable modulus, direction control, synchronous load/clear, an enable prescaler, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. All outputs are registered.

---
 rtl/step_counter.sv | 83 ++++++++
 tb/tb_step_counter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_counter.sv
// ============================================================================
//  Module      : step_counter
//  Description : Up/down step counter with a programmable modulus, a
//                prescaler, wrap or saturate mode, a terminal-count pulse
//                and a sticky overflow flag. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module step_counter #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX      = {WIDTH{1'b1}},
    parameter int unsigned      PRESCALE = 1,
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam int unsigned    c_PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PW-1:0] c_PS_LAST = c_PW'(PRESCALE - 1);

    logic [c_PW-1:0]  r_pre;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_step;

    assign w_load_clamped = (load_val > MAX) ? MAX : load_val;
    assign w_step         = en && (r_pre == c_PS_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            r_pre <= '0;
        end else if (clr) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
            r_pre <= '0;
        end else if (load) begin
            // A load on a step cycle discards the step and restarts the phase.
            count <= w_load_clamped;
            tc    <= 1'b0;
            r_pre <= '0;
        end else begin
            tc <= 1'b0;
            if (w_step) begin
                r_pre <= '0;
                if (up) begin
                    if (count == MAX) begin
                        count <= SATURATE ? MAX : '0;
                        tc    <= 1'b1;
                        ovf   <= 1'b1;
                    end else begin
                        count <= count + WIDTH'(1);
                    end
                end else begin
                    if (count == '0) begin
                        count <= SATURATE ? '0 : MAX;
                        tc    <= 1'b1;
                        ovf   <= 1'b1;
                    end else begin
                        count <= count - WIDTH'(1);
                    end
                end
            end else if (en) begin
                r_pre <= r_pre + c_PW'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_step_counter.sv
// ============================================================================
//  Module      : tb_step_counter
//  Description : Directed self-checking bench for step_counter, using four
//                differently parameterised instances on one clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_step_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Defaults: WIDTH=8, MAX=255, PRESCALE=1, wrap
    logic       d_en = 0, d_up = 0, d_load = 0, d_clr = 0;
    logic [7:0] d_load_val = '0, d_count;
    logic       d_tc, d_ovf;
    // MAX=9, PRESCALE=3, wrap
    logic       m_en = 0, m_up = 0, m_load = 0, m_clr = 0;
    logic [7:0] m_load_val = '0, m_count;
    logic       m_tc, m_ovf;
    // MAX=255, PRESCALE=1, saturate
    logic       s_en = 0, s_up = 0, s_load = 0, s_clr = 0;
    logic [7:0] s_load_val = '0, s_count;
    logic       s_tc, s_ovf;
    // MAX=255, PRESCALE=4, wrap
    logic       g_en = 0, g_up = 0, g_load = 0, g_clr = 0;
    logic [7:0] g_load_val = '0, g_count;
    logic       g_tc, g_ovf;

    step_counter #(.WIDTH(8)) u_def (
        .clk(clk), .rst(rst), .en(d_en), .up(d_up), .load(d_load),
        .load_val(d_load_val), .clr(d_clr), .count(d_count), .tc(d_tc), .ovf(d_ovf)
    );
    step_counter #(.WIDTH(8), .MAX(8'd9), .PRESCALE(3)) u_mod (
        .clk(clk), .rst(rst), .en(m_en), .up(m_up), .load(m_load),
        .load_val(m_load_val), .clr(m_clr), .count(m_count), .tc(m_tc), .ovf(m_ovf)
    );
    step_counter #(.WIDTH(8), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(s_en), .up(s_up), .load(s_load),
        .load_val(s_load_val), .clr(s_clr), .count(s_count), .tc(s_tc), .ovf(s_ovf)
    );
    step_counter #(.WIDTH(8), .PRESCALE(4)) u_gate (
        .clk(clk), .rst(rst), .en(g_en), .up(g_up), .load(g_load),
        .load_val(g_load_val), .clr(g_clr), .count(g_count), .tc(g_tc), .ovf(g_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_vec++;
        if ({d_count, d_tc, d_ovf, m_count, m_tc, m_ovf} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_dm: got d=%0d/%b/%b m=%0d/%b/%b, want all 0",
                     d_count, d_tc, d_ovf, m_count, m_tc, m_ovf);
        end
        n_vec++;
        if ({s_count, s_tc, s_ovf, g_count, g_tc, g_ovf} !== 20'h0) begin
            n_err++;
            $display("FAIL reset_sg: got s=%0d/%b/%b g=%0d/%b/%b, want all 0",
                     s_count, s_tc, s_ovf, g_count, g_tc, g_ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_wrap_default();
        logic [7:0] exp_c;
        d_en = 1; d_up = 1;
        for (int k = 1; k <= 260; k++) begin
            tick();
            exp_c = 8'(k % 256);
            n_vec++;
            if ({d_count, d_tc, d_ovf} !== {exp_c, (k == 256), (k >= 256)}) begin
                n_err++;
                $display("FAIL wrap_default k=%0d: got %0d/%b/%b, want %0d/%b/%b",
                         k, d_count, d_tc, d_ovf, exp_c, (k == 256), (k >= 256));
            end
        end
        d_en = 0;
    endtask

    task automatic test_modulus_prescale();
        logic [7:0] exp_c;
        m_en = 1; m_up = 1;
        for (int k = 1; k <= 33; k++) begin
            tick();
            exp_c = 8'((k / 3) % 10);
            n_vec++;
            if ({m_count, m_tc, m_ovf} !== {exp_c, (k == 30), (k >= 30)}) begin
                n_err++;
                $display("FAIL mod_prescale k=%0d: got %0d/%b/%b, want %0d/%b/%b",
                         k, m_count, m_tc, m_ovf, exp_c, (k == 30), (k >= 30));
            end
        end
        m_en = 0;
    endtask

    task automatic test_saturate();
        logic [7:0] exp_c [4] = '{8'd1, 8'd0, 8'd0, 8'd0};
        logic       exp_t [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_o [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        s_load = 1; s_load_val = 8'd2;
        tick();
        s_load = 0;
        n_vec++;
        if ({s_count, s_tc, s_ovf} !== {8'd2, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL sat_load: got %0d/%b/%b, want 2/0/0", s_count, s_tc, s_ovf);
        end
        s_en = 1; s_up = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_vec++;
            if ({s_count, s_tc, s_ovf} !== {exp_c[k], exp_t[k], exp_o[k]}) begin
                n_err++;
                $display("FAIL sat_down k=%0d: got %0d/%b/%b, want %0d/%b/%b",
                         k, s_count, s_tc, s_ovf, exp_c[k], exp_t[k], exp_o[k]);
            end
        end
        s_en = 0; s_clr = 1;
        tick();
        s_clr = 0;
        n_vec++;
        if ({s_count, s_tc, s_ovf} !== {8'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL sat_clr: got %0d/%b/%b, want 0/0/0", s_count, s_tc, s_ovf);
        end
        // Saturate at the top: 254 -> 255 -> 255 with tc
        s_load = 1; s_load_val = 8'd254;
        tick();
        s_load = 0; s_en = 1; s_up = 1;
        tick();
        n_vec++;
        if ({s_count, s_tc, s_ovf} !== {8'd255, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL sat_up1: got %0d/%b/%b, want 255/0/0", s_count, s_tc, s_ovf);
        end
        tick();
        s_en = 0;
        n_vec++;
        if ({s_count, s_tc, s_ovf} !== {8'd255, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL sat_up2: got %0d/%b/%b, want 255/1/1", s_count, s_tc, s_ovf);
        end
        tick();
        n_vec++;
        if (s_tc !== 1'b0) begin
            n_err++;
            $display("FAIL sat_tc_drop: got tc=%b, want 0", s_tc);
        end
    endtask

    task automatic test_load_priority();
        // m_ovf is 1 from the modulus test; a load must leave it alone.
        m_load = 1; m_load_val = 8'd200;
        tick();
        m_load = 0;
        n_vec++;
        if ({m_count, m_tc, m_ovf} !== {8'd9, 1'b0, 1'b1}) begin
            n_err++;
            $display("FAIL load_clamp: got %0d/%b/%b, want 9/0/1", m_count, m_tc, m_ovf);
        end
        m_load = 1; m_clr = 1; m_load_val = 8'd4;
        tick();
        m_load = 0; m_clr = 0;
        n_vec++;
        if ({m_count, m_tc, m_ovf} !== {8'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL clr_over_load: got %0d/%b/%b, want 0/0/0", m_count, m_tc, m_ovf);
        end
        m_en = 1; m_up = 1;
        tick();
        tick();
        m_load = 1; m_load_val = 8'd5;
        tick();
        m_load = 0;
        n_vec++;
        if (m_count !== 8'd5) begin
            n_err++;
            $display("FAIL load_on_step: got count=%0d, want 5", m_count);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_vec++;
            if (m_count !== ((k == 3) ? 8'd6 : 8'd5)) begin
                n_err++;
                $display("FAIL load_restart k=%0d: got count=%0d, want %0d",
                         k, m_count, (k == 3) ? 6 : 5);
            end
        end
        m_en = 0;
    endtask

    task automatic test_enable_gating();
        logic [8:0] en_pat = 9'b11_00000_11;
        int         n_en = 0;
        g_up = 1;
        for (int k = 8; k >= 0; k--) begin
            g_en = en_pat[k];
            tick();
            if (en_pat[k]) n_en++;
            n_vec++;
            if ({g_count, g_tc} !== {((n_en >= 4) ? 8'd1 : 8'd0), 1'b0}) begin
                n_err++;
                $display("FAIL en_gate enabled=%0d: got %0d/%b, want %0d/0",
                         n_en, g_count, g_tc, (n_en >= 4) ? 1 : 0);
            end
        end
        g_en = 0;
    endtask

    task automatic test_async_reset();
        // Underflow to set ovf, then load 37 with ovf kept high.
        g_load = 1; g_load_val = 8'd0;
        tick();
        g_load = 0; g_en = 1; g_up = 0;
        for (int k = 0; k < 4; k++) tick();
        g_en = 0;
        n_vec++;
        if ({g_count, g_tc, g_ovf} !== {8'd255, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL underflow: got %0d/%b/%b, want 255/1/1", g_count, g_tc, g_ovf);
        end
        g_load = 1; g_load_val = 8'd37;
        tick();
        g_load = 0; g_en = 1; g_up = 1;
        tick();
        n_vec++;
        if ({g_count, g_ovf} !== {8'd37, 1'b1}) begin
            n_err++;
            $display("FAIL pre_rst: got %0d/ovf=%b, want 37/1", g_count, g_ovf);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({g_count, g_tc, g_ovf} !== {8'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL async_rst: got %0d/%b/%b, want 0/0/0", g_count, g_tc, g_ovf);
        end
        tick();
        #2 rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_vec++;
            if (g_count !== ((k >= 4) ? 8'd1 : 8'd0)) begin
                n_err++;
                $display("FAIL rst_release k=%0d: got count=%0d, want %0d",
                         k, g_count, (k >= 4) ? 1 : 0);
            end
        end
        g_en = 0;
    endtask

    initial begin
        test_reset();
        test_wrap_default();
        test_modulus_prescale();
        test_saturate();
        test_load_priority();
        test_enable_gating();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
